// File: rtl/conv_ctrl.sv
// Sequencer for a 3x3, stride-1, unpadded convolution over a row-major feature map.
// Fetches each window pixel by pixel, presents it to the datapath, and hands the result downstream.
module conv_ctrl #(
  parameter int unsigned IMG_H  = 8,
  parameter int unsigned IMG_W  = 8,
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              ifm_rd_en,
  output logic [ADDR_W-1:0] ifm_addr,
  input  logic [7:0]        ifm_rdata,
  output logic [71:0]       conv_win,
  input  logic [23:0]       conv_result,
  output logic [23:0]       out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int unsigned ROW_W = $clog2(IMG_H);
  localparam int unsigned COL_W = $clog2(IMG_W);
  localparam int unsigned K_W   = 4;
  localparam int unsigned PIX_W = 8;
  localparam int unsigned WIN_W = 72;
  localparam int unsigned RES_W = 24;

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_H - 3);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_W - 3);
  localparam logic [K_W-1:0]   LAST_K   = K_W'(8);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    DRAIN = 3'd2,
    CALC  = 3'd3,
    OUT   = 3'd4,
    FIN   = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [K_W-1:0]     k_q, k_d;
  logic               cap_vld_q;
  logic [K_W-1:0]     cap_k_q;

  logic               busy_d, done_d, rd_en_d, out_valid_d;
  logic [ADDR_W-1:0]  addr_d;
  logic [WIN_W-1:0]   win_d;
  logic [RES_W-1:0]   out_data_d;
  int unsigned        addr_full;

  // Next-state, counters and next values of every registered output.
  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    k_d         = k_q;
    win_d       = conv_win;
    out_data_d  = out_data;
    addr_d      = ifm_addr;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    rd_en_d     = 1'b0;
    out_valid_d = 1'b0;
    addr_full   = 32'd0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
          row_d   = '0;
          col_d   = '0;
          k_d     = '0;
        end
      end
      FETCH: begin
        if (k_q == LAST_K) begin
          state_d = DRAIN;
        end else begin
          k_d = k_q + K_W'(1);
        end
      end
      DRAIN: state_d = CALC;
      CALC: begin
        out_data_d = conv_result;
        state_d    = OUT;
      end
      OUT: begin
        if (out_ready) begin
          k_d = '0;
          if (row_q == LAST_ROW && col_q == LAST_COL) begin
            state_d = FIN;
          end else begin
            state_d = FETCH;
            if (col_q < LAST_COL) begin
              col_d = col_q + COL_W'(1);
            end else begin
              col_d = '0;
              row_d = row_q + ROW_W'(1);
            end
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Pixel read one cycle ago is on ifm_rdata now; drop it into its window slot.
    if (cap_vld_q) begin
      win_d[32'(cap_k_q) * PIX_W +: PIX_W] = ifm_rdata;
    end

    addr_full = (32'(row_d) + 32'(k_d) / 32'd3) * IMG_W + 32'(col_d) + 32'(k_d) % 32'd3;
    if (state_d == FETCH) begin
      addr_d = ADDR_W'(addr_full);
    end

    busy_d      = (state_d != IDLE);
    done_d      = (state_d == FIN);
    rd_en_d     = (state_d == FETCH);
    out_valid_d = (state_d == OUT);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      row_q     <= '0;
      col_q     <= '0;
      k_q       <= '0;
      cap_vld_q <= 1'b0;
      cap_k_q   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      ifm_rd_en <= 1'b0;
      ifm_addr  <= '0;
      conv_win  <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      k_q       <= k_d;
      cap_vld_q <= ifm_rd_en;
      cap_k_q   <= k_q;
      busy      <= busy_d;
      done      <= done_d;
      ifm_rd_en <= rd_en_d;
      ifm_addr  <= addr_d;
      conv_win  <= win_d;
      out_data  <= out_data_d;
      out_valid <= out_valid_d;
    end
  end

endmodule
